// File: rtl/cap_sense_pkg.sv
// Shared types and defaults for the capacitive-sense measurement controller.
// Pad patterns are kept here so the FSM reads as a sequence of named states.
package cap_sense_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DISCHARGE,
        CHARGE,
        ACCUM,
        DONE
    } state_t;

    typedef struct packed {
        logic sense_oe;
        logic sense_out;
        logic drive_oe;
        logic drive_out;
    } pads_t;

    localparam int CNT_W_DEF            = 16;
    localparam int DISCHARGE_CYCLES_DEF = 64;
    localparam int ACC_LOG2_DEF         = 2;

    localparam pads_t PADS_IDLE = '{sense_oe: 1'b1, sense_out: 1'b0,
                                    drive_oe: 1'b0, drive_out: 1'b0};
    localparam pads_t PADS_DIS  = '{sense_oe: 1'b1, sense_out: 1'b0,
                                    drive_oe: 1'b1, drive_out: 1'b0};
    localparam pads_t PADS_CHG  = '{sense_oe: 1'b0, sense_out: 1'b0,
                                    drive_oe: 1'b1, drive_out: 1'b1};
    localparam pads_t PADS_ACC  = '{sense_oe: 1'b1, sense_out: 1'b0,
                                    drive_oe: 1'b1, drive_out: 1'b0};

    function automatic int res_width(input int cnt_w, input int acc_log2);
        return cnt_w + acc_log2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous comparator output.
// Both stages clear to 0 on reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ff_q <= 2'b00;
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/cap_sense_ctrl.sv
// Capacitive-sense measurement FSM: discharge, timed charge, accumulate.
// The count measures cycles until the synchronized comparator trips.
module cap_sense_ctrl
    import cap_sense_pkg::*;
#(
    parameter int CNT_W            = CNT_W_DEF,
    parameter int DISCHARGE_CYCLES = DISCHARGE_CYCLES_DEF,
    parameter int ACC_LOG2         = ACC_LOG2_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    output logic                                   busy,
    output logic [res_width(CNT_W, ACC_LOG2)-1:0]  result,
    output logic                                   result_valid,
    output logic                                   timeout,
    output logic                                   sense_oe,
    output logic                                   sense_out,
    output logic                                   drive_oe,
    output logic                                   drive_out,
    input  logic                                   sense_in
);

    localparam int RES_W = res_width(CNT_W, ACC_LOG2);
    localparam int IDX_W = (ACC_LOG2 > 0) ? ACC_LOG2 : 1;
    localparam int DC_W  = $clog2(DISCHARGE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_MAX - 1'b1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << ACC_LOG2) - 1);
    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DISCHARGE_CYCLES - 1);

    state_t            state_q;
    pads_t             pads_q;
    logic [DC_W-1:0]   dcnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [RES_W-1:0]  acc_q;
    logic [RES_W-1:0]  acc_d;
    logic [RES_W-1:0]  result_q;
    logic              busy_q;
    logic              valid_q;
    logic              timeout_q;
    logic              sin_s;

    sync_2ff u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (sense_in),
        .q_o   (sin_s)
    );

    assign acc_d = acc_q + RES_W'(cnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pads_q    <= PADS_IDLE;
            dcnt_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q     <= '0;
                        idx_q     <= '0;
                        timeout_q <= 1'b0;
                        dcnt_q    <= '0;
                        busy_q    <= 1'b1;
                        pads_q    <= PADS_DIS;
                        state_q   <= DISCHARGE;
                    end
                end
                DISCHARGE: begin
                    // Hold past the nominal length while the comparator is still high.
                    if (dcnt_q != DC_LAST) begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end else if (!sin_s) begin
                        cnt_q   <= '0;
                        pads_q  <= PADS_CHG;
                        state_q <= CHARGE;
                    end
                end
                CHARGE: begin
                    if (sin_s) begin
                        pads_q  <= PADS_ACC;
                        state_q <= ACCUM;
                    end else if (cnt_q == CNT_TRIP) begin
                        cnt_q     <= CNT_MAX;
                        timeout_q <= 1'b1;
                        result_q  <= '1;
                        valid_q   <= 1'b1;
                        pads_q    <= PADS_IDLE;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    if (idx_q == IDX_LAST) begin
                        result_q <= acc_d;
                        valid_q  <= 1'b1;
                        pads_q   <= PADS_IDLE;
                        state_q  <= DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        dcnt_q  <= '0;
                        pads_q  <= PADS_DIS;
                        state_q <= DISCHARGE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    pads_q  <= PADS_IDLE;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign timeout      = timeout_q;
    assign sense_oe     = pads_q.sense_oe;
    assign sense_out    = pads_q.sense_out;
    assign drive_oe     = pads_q.drive_oe;
    assign drive_out    = pads_q.drive_out;

endmodule

// File: tb/tb_cap_sense_ctrl.sv
// Scoreboard bench for cap_sense_ctrl with digital stub and RC pad models.
// A 16-bit instance covers normal flows; an 8-bit instance covers timeout.
module tb_cap_sense_ctrl;

    localparam int RW16 = 18;
    localparam int RW8  = 10;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic rst = 1'b1;
    logic start16 = 1'b0;
    logic start8 = 1'b0;

    logic busy16, rv16, to16, so16, sd16, do16, dd16, sin16;
    logic [RW16-1:0] res16;
    logic busy8, rv8, to8, so8, sd8, do8, dd8;
    logic [RW8-1:0] res8;
    logic sin8 = 1'b0;

    logic dig_in = 1'b0;
    logic rc_in = 1'b0;
    int   mode = 0;
    real  v = 0.0;
    int   chg_cyc = 0;
    int   dis_cyc = 0;

    assign sin16 = (mode == 2) ? rc_in : dig_in;

    cap_sense_ctrl u16 (
        .clk(clk), .rst(rst), .start(start16), .busy(busy16),
        .result(res16), .result_valid(rv16), .timeout(to16),
        .sense_oe(so16), .sense_out(sd16), .drive_oe(do16),
        .drive_out(dd16), .sense_in(sin16)
    );

    cap_sense_ctrl #(.CNT_W(8), .DISCHARGE_CYCLES(4), .ACC_LOG2(2)) u8 (
        .clk(clk), .rst(rst), .start(start8), .busy(busy8),
        .result(res8), .result_valid(rv8), .timeout(to8),
        .sense_oe(so8), .sense_out(sd8), .drive_oe(do8),
        .drive_out(dd8), .sense_in(sin8)
    );

    // Digital stub: rises 50 cycles after charge entry; mode 1 also holds
    // the comparator high for ~100 cycles into each discharge.
    always @(posedge clk) begin
        chg_cyc <= so16 ? 0 : chg_cyc + 1;
        dis_cyc <= (so16 && do16) ? dis_cyc + 1 : 0;
        dig_in  <= (!so16 && chg_cyc >= 49) ||
                   (mode == 1 && so16 && do16 && dis_cyc < 99);
    end

    // RC pad: tau = 100 cycles, comparator hysteresis 0.3/0.7 of Vcc.
    always @(posedge clk) begin
        #37;
        if (so16 && !sd16)
            v = 0.0;
        else if (!so16 && do16 && dd16)
            v = v + (1.0 - v) * (1.0 - $exp(-0.01));
        if (!rc_in && v >= 0.7)
            rc_in = 1'b1;
        else if (rc_in && v <= 0.3)
            rc_in = 1'b0;
    end

    typedef struct {
        int lo;
        int hi;
        bit to;
        int llo;
        int lhi;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    exp_t e16, e8, e;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t16 = 0;
    int t8 = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start16 && !busy16 && !rst) t16 <= cyc + 1;
        if (start8 && !busy8 && !rst) t8 <= cyc + 1;
    end

    task automatic chk(input string nm, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic chkr(input string nm, input longint got,
                        input longint lo, input longint hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", nm, got, lo, hi);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rv16) begin
            chk("rv16_expected", int'(q16.size() != 0), 1);
            if (q16.size() != 0) begin
                e16 = q16.pop_front();
                chkr("res16", res16, e16.lo, e16.hi);
                chk("to16", to16, e16.to);
                chkr("lat16", cyc - t16, e16.llo, e16.lhi);
                chk("busy16_in_done", busy16, 1);
            end
            @(negedge clk);
            chk("rv16_single_pulse", rv16, 0);
        end
    end

    initial forever begin
        @(negedge clk);
        if (rv8) begin
            chk("rv8_expected", int'(q8.size() != 0), 1);
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                chkr("res8", res8, e8.lo, e8.hi);
                chk("to8", to8, e8.to);
                chkr("lat8", cyc - t8, e8.llo, e8.lhi);
            end
            @(negedge clk);
            chk("rv8_single_pulse", rv8, 0);
        end
    end

    task automatic issue16(input int m, input exp_t x);
        mode = m;
        q16.push_back(x);
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        chk("busy16_after_start", busy16, 1);
        chk("pads16_discharge", {so16, sd16, do16, dd16}, 4'b1010);
    endtask

    task automatic wait_idle16(input int lim);
        int n = 0;
        while (busy16 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("idle16_in_time", int'(n < lim), 1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy16, 0);
        chk("rst_rv", rv16, 0);
        chk("rst_to", to16, 0);
        chk("rst_res", res16, 0);
        chk("rst_pads", {so16, sd16, do16, dd16}, 4'b1000);
        rst = 1'b0;
        @(negedge clk);

        e = '{208, 208, 1'b0, 470, 475};
        issue16(0, e);
        wait_idle16(2000);
        chk("idle_pads", {so16, sd16, do16, dd16}, 4'b1000);
        chk("res16_holds", res16, 208);

        issue16(0, e);
        repeat (100) @(negedge clk);
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        n = 0;
        while (!rv16 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("rv16_seen", int'(n < 1000), 1);
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (600) @(negedge clk);
        chk("start_in_done_ignored", busy16, 0);
        chk("q16_drained", q16.size(), 0);

        e = '{1023, 1023, 1'b1, 257, 261};
        q8.push_back(e);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (busy8 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle8_in_time", int'(n < 1000), 1);
        repeat (5) @(negedge clk);
        chk("to8_sticky", to8, 1);
        chk("res8_holds", res8, 1023);

        e = '{208, 208, 1'b0, 572, 1000};
        issue16(1, e);
        wait_idle16(3000);

        e = '{208, 208, 1'b0, 470, 475};
        issue16(0, e);
        n = 0;
        while (so16 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("charge_reached", so16, 0);
        repeat (10) @(negedge clk);
        #10 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy16, 0);
        chk("mid_rst_rv", rv16, 0);
        chk("mid_rst_res", res16, 0);
        chk("mid_rst_pads", {so16, sd16, do16, dd16}, 4'b1000);
        chk("mid_rst_to8", to8, 0);
        q16.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_rv_after_rst", q16.size(), 0);

        issue16(0, e);
        wait_idle16(2000);

        e = '{480, 496, 1'b0, 700, 800};
        issue16(2, e);
        wait_idle16(3000);

        chk("q16_empty", q16.size(), 0);
        chk("q8_empty", q8.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cap_sense_ctrl.md
# cap_sense_ctrl

Synthesizable measurement controller for one capacitive-sense channel, the digital stage directly upstream of the RC pad/sense model. It drives the sense and drive pad enables and levels, discharges the sense capacitor, then releases the sense pin and charges it through the external resistor. It counts clock cycles until the hysteretic `sense_in` comparator trips and accumulates 2^ACC_LOG2 such samples into one result word.

## Interface
- `CNT_W`, 16: width of per-sample charge counter; per-sample timeout at 2^CNT_W-1 cycles.
- `DISCHARGE_CYCLES`, 64: cycles the sense pin is held low before each charge phase; must be ≥1.
- `ACC_LOG2`, 2: log2 of samples accumulated per result (4 by default); 0 allowed.
- `clk` in 1: single clock.
- `rst` in 1: reset; one clock, reset is asynchronous and active-high.
- `start` in 1: request one measurement; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` accepted until the DONE cycle inclusive.
- `result` out CNT_W+ACC_LOG2: sum of sample counts; holds value until next DONE.
- `result_valid` out 1: one-cycle pulse in DONE.
- `timeout` out 1: qualifies `result` (same timing); sticky until next accepted `start`.
- `sense_oe`, `sense_out` out 1 each: sense pad output enable and level.
- `drive_oe`, `drive_out` out 1 each: drive pad output enable and level.
- `sense_in` in 1: asynchronous comparator output from the pad model.

## Operation
- All outputs are registered, with no combinational path from input to pad. Reset values:
  - `sense_oe`=1, `sense_out`=0, `drive_oe`=0, `drive_out`=0.
  - `busy`=0, `result_valid`=0, `timeout`=0, `result`=0.
  - State IDLE.
- `sense_in` passes through a 2-flop synchronizer. Only the synchronized value `sin_s` is used.
- IDLE: pads hold the reset pattern, so the capacitor is held discharged. On `start`=1, clear the accumulator, sample index and `timeout`, then go to DISCHARGE.
- DISCHARGE:
  - Pads: `sense_oe`=1, `sense_out`=0, `drive_oe`=1, `drive_out`=0.
  - Stay exactly DISCHARGE_CYCLES cycles, then go to CHARGE with the counter cleared to 0.
  - If `sin_s` is still 1 at exit, stay in DISCHARGE (extend) until `sin_s`=0.
- CHARGE:
  - Pads: `sense_oe`=0, `drive_oe`=1, `drive_out`=1.
  - The counter increments every cycle in which `sin_s`=0.
  - The first cycle with `sin_s`=1 ends the sample with the count frozen, then go to ACCUM.
  - If the counter reaches 2^CNT_W-1 with `sin_s` still 0: set `timeout`, force `result` to all-ones, and go to DONE. Remaining samples are abandoned.
- ACCUM:
  - Pads: `drive_out`=0, with `sense_oe`=1 and `sense_out`=0, to start discharging.
  - acc += zero-extended count; no overflow is possible by width.
  - If sample index = 2^ACC_LOG2-1, `result`←acc and go to DONE. Otherwise increment the index and go to DISCHARGE.
- DONE: assert `result_valid` for one cycle, pads return to the IDLE pattern, then go to IDLE. `start` in DONE is ignored.
- `start` while `busy` is ignored and never queued.
- Reset mid-operation: the FSM immediately returns to IDLE and all outputs take their reset values. The partial accumulator is discarded and no `result_valid` is issued.

## Timing
- `start` in cycle 0 → DISCHARGE from cycle 1, with `busy`=1 from cycle 1.
- The sync adds 2 cycles, so the count equals (cycles from CHARGE entry to raw `sense_in` rise) + 2, ±1 for asynchronous sampling.
- Per-sample overhead with no extension: DISCHARGE_CYCLES + 1 (ACCUM), plus count+1 CHARGE cycles.
- The last ACCUM is followed by DONE in the next cycle, and IDLE in the cycle after that.
- With the reference pad values (C=10 pF, Rext=1 MΩ, 0.7·Vcc threshold ≈ 1.204·τ ≈ 12.04 µs) and a 10 MHz clock, the expected count is about 120–124 per sample.

## Structure
- Package `cap_sense_pkg`:
  - `state_t` enum (IDLE, DISCHARGE, CHARGE, ACCUM, DONE).
  - Default parameter constants.
  - A localparam function for the result width.
- Sub-module `sync_2ff`: reset to 0, single-bit 2-flop synchronizer. Everything else is a single FSM plus counter/accumulator in `cap_sense_ctrl`.

## Test plan
- Reset mid-CHARGE with a digital stub pad → all outputs at reset values within the same cycle; next `start` gives a fresh, correct result.
- Stub raises `sense_in` exactly 50 cycles after CHARGE entry, with CNT_W=16 and ACC_LOG2=2 → `result` = 4×52 = 208, `timeout`=0, `result_valid` a single pulse.
- Stub never raises `sense_in`, with CNT_W=8 → `timeout`=1 and `result` all-ones, after 255 CHARGE cycles.
- Stub holds `sense_in`=1 for 100 cycles into DISCHARGE → DISCHARGE extends until `sin_s`=0, and the count is unaffected.
- `start` pulsed during `busy` and during DONE → ignored; exactly one `result_valid` per accepted `start`.
- Closed loop with the RC pad model at 10 MHz → per-sample counts 120–124; `result` in 480–496.
